// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for the shared line BRAM: data side has fixed priority,
// a streak counter bounds instruction starvation. Optional watchdog: ARB_TIMEOUT_EN.
module bram_port_arbiter #(
  parameter int ADDR_BITS      = 15,
  parameter int DATA_BITS      = 128,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic                 i_write,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic                 i_rdy,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic                 d_rdy,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_valid,
  output logic                 owner,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t               state_reg;
  logic [3:0]           streak_reg;
  logic                 i_rdy_reg;
  logic                 d_rdy_reg;
  logic [DATA_BITS-1:0] rdata_reg;
  logic                 mem_req_reg;
  logic                 mem_write_reg;
  logic [ADDR_BITS-1:0] mem_addr_reg;
  logic [DATA_BITS-1:0] mem_wdata_reg;
  logic                 owner_reg;

  // Instruction wins only when alone or when data has used up its streak.
  logic pick_instr;
  logic any_req;
  assign any_req    = i_req | d_req;
  assign pick_instr = i_req & (~d_req | (streak_reg >= STREAK_MAX));

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_reg;
  logic          err_timeout_reg;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      i_rdy_reg     <= 1'b0;
      d_rdy_reg     <= 1'b0;
      rdata_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      owner_reg     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timer_reg       <= '0;
      err_timeout_reg <= 1'b0;
`endif
    end else begin
      i_rdy_reg <= 1'b0;
      d_rdy_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg   <= GRANT;
            mem_req_reg <= 1'b1;
            owner_reg   <= pick_instr;
            if (pick_instr) begin
              mem_write_reg <= i_write;
              mem_addr_reg  <= i_addr;
              mem_wdata_reg <= i_wdata;
              streak_reg    <= '0;
            end else begin
              mem_write_reg <= d_write;
              mem_addr_reg  <= d_addr;
              mem_wdata_reg <= d_wdata;
              if (!i_req)
                streak_reg <= '0;
              else if (streak_reg < STREAK_MAX)
                streak_reg <= streak_reg + 4'd1;
            end
`ifdef ARB_TIMEOUT_EN
            timer_reg <= '0;
`endif
          end
        end
        GRANT: begin
          if (mem_valid) begin
            state_reg   <= RESP;
            mem_req_reg <= 1'b0;
            rdata_reg   <= mem_rdata;
            if (owner_reg) i_rdy_reg <= 1'b1;
            else           d_rdy_reg <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          // Abort: complete the owner with a zero line and flag the error.
          else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_reg       <= RESP;
            mem_req_reg     <= 1'b0;
            rdata_reg       <= '0;
            err_timeout_reg <= 1'b1;
            if (owner_reg) i_rdy_reg <= 1'b1;
            else           d_rdy_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
`endif
        end
        RESP:    state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign i_rdy     = i_rdy_reg;
  assign d_rdy     = d_rdy_reg;
  assign rdata     = rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner     = owner_reg;
`ifdef ARB_TIMEOUT_EN
  assign err_timeout = err_timeout_reg;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: table of single transactions plus
// hand-written reset, starvation, back-to-back and watchdog sequences.
module tb_bram_port_arbiter;

  localparam int AB = 15;
  localparam int DB = 128;

  logic          sys_clock = 1'b0;
  logic          reset;
  logic          i_req, i_write, i_rdy;
  logic [AB-1:0] i_addr;
  logic [DB-1:0] i_wdata;
  logic          d_req, d_write, d_rdy;
  logic [AB-1:0] d_addr;
  logic [DB-1:0] d_wdata;
  logic [DB-1:0] rdata;
  logic          mem_req, mem_write;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata, mem_rdata;
  logic          mem_valid;
  logic          owner, err_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clock = ~sys_clock;

  bram_port_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .sys_clock(sys_clock), .reset(reset),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdy(i_rdy),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy),
    .rdata(rdata), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .owner(owner), .err_timeout(err_timeout)
  );

  typedef struct {
    logic          is_i;
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    int            lat;
    logic [DB-1:0] ret;
    logic          exp_owner;
    logic [DB-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    if (v.is_i) begin
      i_req = 1'b1; i_write = v.wr; i_addr = v.addr; i_wdata = v.wdata;
    end else begin
      d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end
    tick();
    chk("grant_mem_req", mem_req, 1'b1);
    chk("grant_mem_write", mem_write, v.wr);
    chkw("grant_mem_addr", DB'(mem_addr), DB'(v.addr));
    chkw("grant_mem_wdata", mem_wdata, v.wdata);
    chk("grant_owner", owner, v.exp_owner);
    for (int k = 1; k < v.lat; k++) begin
      tick();
      chk("hold_mem_req", mem_req, 1'b1);
    end
    mem_valid = 1'b1;
    mem_rdata = v.ret;
    tick();
    mem_valid = 1'b0;
    mem_rdata = '0;
    chk("resp_i_rdy", i_rdy, v.is_i);
    chk("resp_d_rdy", d_rdy, ~v.is_i);
    chk("resp_mem_req", mem_req, 1'b0);
    chk("resp_err", err_timeout, 1'b0);
    if (!v.wr) chkw("resp_rdata", rdata, v.exp_rdata);
    tick();
    chk("gap_i_rdy", i_rdy, 1'b0);
    chk("gap_d_rdy", d_rdy, 1'b0);
    chk("gap_mem_req", mem_req, 1'b0);
    $display("txn %0d side=%s wr=%0d addr=%h lat=%0d rdata=%h", idx,
             v.is_i ? "I" : "D", v.wr, v.addr, v.lat, rdata);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    logic grants[$];
    logic exp_order[6];
    int   n_i_rdy, n_d_rdy, both_rdy;
    logic prev_req;

    vecs[0] = '{1'b0, 1'b0, 15'h0123, '0, 2,
                {16{8'hA5}}, 1'b0, {16{8'hA5}}};
    vecs[1] = '{1'b1, 1'b1, 15'h07FF, 128'h0123456789ABCDEF0123456789ABCDEF, 1,
                '0, 1'b1, '0};
    vecs[2] = '{1'b1, 1'b0, 15'h0001, '0, 3,
                128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b1,
                128'hDEADBEEF_00000000_CAFEF00D_12345678};
    vecs[3] = '{1'b0, 1'b1, 15'h7FFF, 128'h5555_0000_AAAA_FFFF_1111_2222_3333_4444, 1,
                '0, 1'b0, '0};
    vecs[4] = '{1'b0, 1'b0, 15'h0000, '0, 1, {DB{1'b1}}, 1'b0, {DB{1'b1}}};

    reset = 1'b1;
    i_req = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_valid = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_i_rdy", i_rdy, 1'b0);
    chk("rst_d_rdy", d_rdy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chkw("rst_rdata", rdata, '0);

    // Reset while a data grant is stalled, then a late mem_valid.
    d_req = 1'b1; d_addr = 15'h0010;
    tick();
    chk("midrst_grant", mem_req, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_d_rdy", d_rdy, 1'b0);
    mem_valid = 1'b1; mem_rdata = {16{8'h3C}};
    tick();
    mem_valid = 1'b0; mem_rdata = '0;
    chk("late_valid_d_rdy", d_rdy, 1'b0);
    chk("late_valid_mem_req", mem_req, 1'b0);
    tick();
    chk("late_valid_d_rdy2", d_rdy, 1'b0);
    chkw("late_valid_rdata", rdata, '0);
    $display("txn reset-mid-grant done");

    for (int t = 0; t < 5; t++) run_txn(t, vecs[t]);

    // Both sides request together; data keeps requesting.
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
    exp_order[3] = 0; exp_order[4] = 1; exp_order[5] = 0;
    n_i_rdy = 0; n_d_rdy = 0; both_rdy = 0; prev_req = 1'b0;
    i_req = 1'b1; i_write = 0; i_addr = 15'h0200;
    d_req = 1'b1; d_write = 0; d_addr = 15'h0300;
    for (int c = 0; c < 80 && (n_i_rdy + n_d_rdy) < 6; c++) begin
      tick();
      if (mem_req && !prev_req) grants.push_back(owner);
      prev_req  = mem_req;
      mem_valid = mem_req;
      if (i_rdy) begin n_i_rdy++; i_req = 1'b0; end
      if (d_rdy) n_d_rdy++;
      if (i_rdy && d_rdy) both_rdy++;
    end
    mem_valid = 1'b0;
    d_req = 1'b0;
    checks++;
    if (grants.size() != 6) begin
      failures++;
      $display("FAIL starve_grant_count actual=%0d required=6", grants.size());
    end else begin
      for (int g = 0; g < 6; g++) chk("starve_order", grants[g], exp_order[g]);
    end
    checks++;
    if (n_i_rdy != 1 || n_d_rdy != 5) begin
      failures++;
      $display("FAIL starve_rdy_counts actual=%0d/%0d required=1/5", n_i_rdy, n_d_rdy);
    end
    checks++;
    if (both_rdy != 0) begin
      failures++;
      $display("FAIL rdy_overlap actual=%0d required=0", both_rdy);
    end
    $display("txn starvation sequence grants=%0d i_rdy=%0d d_rdy=%0d", grants.size(), n_i_rdy, n_d_rdy);
    tick(); tick(); tick();

    // Back-to-back data reads with one GAP cycle between them.
    d_req = 1'b1; d_write = 0; d_addr = 15'h0042;
    tick();
    chk("b2b_grant1", mem_req, 1'b1);
    mem_valid = 1'b1; mem_rdata = {16{8'h11}};
    tick();
    mem_valid = 1'b0;
    chk("b2b_resp_rdy", d_rdy, 1'b1);
    chk("b2b_resp_mem_req", mem_req, 1'b0);
    chkw("b2b_resp_rdata", rdata, {16{8'h11}});
    d_req = 1'b0;
    tick();
    chk("b2b_gap_mem_req", mem_req, 1'b0);
    chk("b2b_gap_rdy", d_rdy, 1'b0);
    d_req = 1'b1; d_addr = 15'h0043;
    tick();
    chk("b2b_idle_mem_req", mem_req, 1'b0);
    tick();
    chk("b2b_grant2", mem_req, 1'b1);
    chkw("b2b_grant2_addr", DB'(mem_addr), DB'(15'h0043));
    mem_valid = 1'b1; mem_rdata = {16{8'h22}};
    tick();
    mem_valid = 1'b0;
    chk("b2b_resp2_rdy", d_rdy, 1'b1);
    chkw("b2b_resp2_rdata", rdata, {16{8'h22}});
    d_req = 1'b0;
    tick(); tick();
    $display("txn back-to-back done");

    // Stalled BRAM: watchdog abort, or an indefinite hold without it.
    d_req = 1'b1; d_write = 0; d_addr = 15'h0555;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      chk("wd_hold_mem_req", mem_req, 1'b1);
      tick();
    end
    chk("wd_last_mem_req", mem_req, 1'b1);
    tick();
    chk("wd_err", err_timeout, 1'b1);
    chk("wd_d_rdy", d_rdy, 1'b1);
    chk("wd_i_rdy", i_rdy, 1'b0);
    chk("wd_mem_req", mem_req, 1'b0);
    chkw("wd_rdata", rdata, '0);
    d_req = 1'b0;
    tick();
    chk("wd_err_pulse", err_timeout, 1'b0);
    tick();
    $display("txn watchdog abort done");
`else
    for (int c = 0; c < 20; c++) begin
      chk("stall_mem_req", mem_req, 1'b1);
      chk("stall_err", err_timeout, 1'b0);
      chk("stall_d_rdy", d_rdy, 1'b0);
      tick();
    end
    mem_valid = 1'b1; mem_rdata = {16{8'h77}};
    tick();
    mem_valid = 1'b0;
    chk("stall_end_rdy", d_rdy, 1'b1);
    chkw("stall_end_rdata", rdata, {16{8'h77}});
    d_req = 1'b0;
    tick(); tick();
    $display("txn stalled grant held then completed");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
